// File: rtl/timer_array.sv
// Multi-channel countdown timer: NUM_CH independent channels, each with
// CTRL/PRESET/COUNT/STATUS registers and a maskable interrupt line.

module timer_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [1:0]       rg,
    input  logic [31:0]      wdata,
    input  logic [31:0]      bm,
    output logic [31:0]      rdata,
    output logic             irq
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t             state, state_nxt;
    logic [2:0]         ctrl;
    logic [2:0]         ctrl_base;
    logic [CNT_W-1:0]   preset;
    logic [CNT_W-1:0]   count;
    logic               pending;

    logic load, dec, set_pend, clr_en;
    logic we_ctrl, we_pre, w1c;

    assign we_ctrl = wr && (rg == 2'd0);
    assign we_pre  = wr && (rg == 2'd1);
    assign w1c     = wr && (rg == 2'd3) && bm[0] && wdata[0];

    // Hardware enable clear is applied first so an overlapping software
    // write (on the bytes it enables) takes precedence.
    assign ctrl_base = {ctrl[2:1], ctrl[0] & ~clr_en};

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        dec       = 1'b0;
        set_pend  = 1'b0;
        clr_en    = 1'b0;
        case (state)
            S_IDLE: if (ctrl[0]) state_nxt = S_LOAD;
            S_LOAD: begin
                load      = 1'b1;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!ctrl[0]) begin
                    state_nxt = S_IDLE;
                end else if (count == '0) begin
                    set_pend  = 1'b1;
                    state_nxt = S_INT;
                end else begin
                    dec = 1'b1;
                end
            end
            S_INT: begin
                if (ctrl[1]) begin
                    state_nxt = S_LOAD;
                end else begin
                    clr_en    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (we_ctrl)
                ctrl <= (ctrl_base & ~bm[2:0]) | (wdata[2:0] & bm[2:0]);
            else
                ctrl <= ctrl_base;
            if (we_pre)
                preset <= (preset & ~bm[CNT_W-1:0]) | (wdata[CNT_W-1:0] & bm[CNT_W-1:0]);
            if (load)
                count <= preset;
            else if (dec)
                count <= count - CNT_W'(1);
            // A same-edge hardware set beats the software clear.
            if (set_pend)
                pending <= 1'b1;
            else if (w1c)
                pending <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (rg)
            2'd0: rdata = {29'b0, ctrl};
            2'd1: rdata = 32'(preset);
            2'd2: rdata = 32'(count);
            2'd3: rdata = {31'b0, pending};
            default: rdata = '0;
        endcase
    end

    assign irq = pending & ctrl[2];
endmodule

module timer_array #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Sel,
    input  logic [3:0]        Addr,
    input  logic [31:0]       WData,
    input  logic [3:0]        Mask,
    input  logic              Write,
    output logic [31:0]       RData,
    output logic [NUM_CH-1:0] IRQ
);
    logic [31:0]              bm;
    logic [NUM_CH-1:0][31:0]  rd;

    for (genvar b = 0; b < 4; b++) begin : g_bm
        assign bm[8*b +: 8] = {8{Mask[b]}};
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_ch #(.CNT_W(CNT_W)) u_ch (
            .clk   (Clk),
            .rst   (Rst),
            .wr    (Sel && Write && (Addr[3:2] == 2'(i))),
            .rg    (Addr[1:0]),
            .wdata (WData),
            .bm    (bm),
            .rdata (rd[i]),
            .irq   (IRQ[i])
        );
    end

    // Channel indices with no instance fall through to zero.
    always_comb begin
        RData = '0;
        if (Sel) begin
            for (int i = 0; i < NUM_CH; i++)
                if (Addr[3:2] == 2'(i)) RData = rd[i];
        end
    end
endmodule
